interpolator: RTL and testbench

- Upsampler for the CIC interpolation chain: emits InterpolationFactor output samples per accepted input sample.
- Default mode is zero-stuffing: phase 0 carries the input word and the other phases carry zero.
- Sits between the sample source and the CIC interpolator integrator/comb stages; it is the mirror of the decimator on the receive side.
- Full ready/valid handshake on both sides; a one-entry holding register sustains back-to-back output with no bubbles.

---
 rtl/cic_pkg.sv | 14 +
 rtl/interpolator_if.sv | 33 +++
 rtl/interpolator.sv | 123 ++++++++++++
 tb/tb_interpolator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants for the CIC interpolation and decimation chain.
// The rate-counter width and largest rate factor are common to the
// interpolator and the decimator, so both range checks use the same helper.
package cic_pkg;

  localparam int CounterLengthBits = 16;
  localparam int MaxRateFactor     = 65535;

  // True when a rate factor fits the shared phase counter.
  function automatic bit rate_factor_ok(input int factor);
    return (factor >= 1) && (factor <= MaxRateFactor);
  endfunction

endpackage

// File: rtl/interpolator_if.sv
// Ready/valid stream bundle for the interpolator: the input sample side and
// the output sample side travel together so a block needs only one bus port.
// slave is the interpolator's view; master is the view of whatever drives it.
interface interpolator_if #(
  parameter int WordLengthBits = 29
);

  logic signed [WordLengthBits-1:0] in;
  logic                             in_valid;
  logic                             in_ready;
  logic signed [WordLengthBits-1:0] out;
  logic                             out_valid;
  logic                             out_ready;

  modport slave (
    input  in,
    input  in_valid,
    output in_ready,
    output out,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in,
    output in_valid,
    input  in_ready,
    input  out,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/interpolator.sv
// Upsampler feeding the CIC interpolator integrator/comb stages.
// Every accepted input word becomes InterpolationFactor output words.
// Default build zero-stuffs: phase 0 carries the word, later phases carry 0.
// Defining INTERPOLATOR_HOLD_EN switches to zero-order hold, where every
// phase repeats the word; handshake, latency and phase counting are unchanged.
// A one-entry pending register takes the next word while the current one is
// still being emitted, so a continuous source gives a gap-free output stream.
module interpolator
  import cic_pkg::*;
#(
  parameter int WordLengthBits      = 29,
  parameter int InterpolationFactor = 50
) (
  input  logic           clk,
  input  logic           rst,
  interpolator_if.slave  bus
);

  typedef logic signed [WordLengthBits-1:0] word_t;
  typedef logic [CounterLengthBits-1:0]     phase_t;

  localparam phase_t LastPhase = phase_t'(InterpolationFactor - 1);

`ifdef INTERPOLATOR_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  if (!rate_factor_ok(InterpolationFactor)) begin : g_bad_factor
    $error("interpolator: InterpolationFactor %0d outside 1..%0d",
           InterpolationFactor, MaxRateFactor);
  end

  word_t  active_word,   active_word_next;
  logic   active_valid,  active_valid_next;
  phase_t phase,         phase_next;
  word_t  out_word,      out_word_next;
  word_t  pending_word,  pending_word_next;
  logic   pending_valid, pending_valid_next;
  logic   in_ready_q;

  logic fire_in;
  logic fire_out;
  logic last;
  logic load;

  assign fire_in  = bus.in_valid & in_ready_q;
  assign fire_out = active_valid & bus.out_ready;
  assign last     = fire_out & (phase == LastPhase);
  // A new word may enter the active slot when nothing is shown or the final
  // phase of the current word is being taken this cycle.
  assign load     = !active_valid | last;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = active_valid;
  assign bus.out       = out_word;

  // Next-state equation shared by the active slot, phase counter and pending
  // register; the output word is precomputed so out comes straight from a flop.
  always_comb begin
    active_word_next   = active_word;
    active_valid_next  = active_valid;
    phase_next         = phase;
    out_word_next      = out_word;
    pending_word_next  = pending_word;
    pending_valid_next = pending_valid;

    if (load) begin
      if (pending_valid) begin
        active_word_next  = pending_word;
        out_word_next     = pending_word;
        phase_next        = '0;
        active_valid_next = 1'b1;
        if (fire_in) begin
          pending_word_next = bus.in;
        end else begin
          pending_valid_next = 1'b0;
        end
      end else if (fire_in) begin
        active_word_next  = bus.in;
        out_word_next     = bus.in;
        phase_next        = '0;
        active_valid_next = 1'b1;
      end else begin
        active_valid_next = 1'b0;
        out_word_next     = '0;
      end
    end else begin
      if (fire_out) begin
        phase_next    = phase + phase_t'(1);
        out_word_next = HoldEn ? active_word : word_t'(0);
      end
      if (fire_in) begin
        pending_word_next  = bus.in;
        pending_valid_next = 1'b1;
      end
    end
  end

  // State registers; in_ready is registered from the pending slot's next
  // value so downstream ready never reaches upstream combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_word   <= '0;
      active_valid  <= 1'b0;
      phase         <= '0;
      out_word      <= '0;
      pending_word  <= '0;
      pending_valid <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      active_word   <= active_word_next;
      active_valid  <= active_valid_next;
      phase         <= phase_next;
      out_word      <= out_word_next;
      pending_word  <= pending_word_next;
      pending_valid <= pending_valid_next;
      in_ready_q    <= !pending_valid_next;
    end
  end

endmodule

// File: tb/tb_interpolator.sv
// Scoreboard bench for interpolator: four instances (factors 4, 3, 1, 8)
// share the stimulus bus, one is selected at a time. Issued words push their
// expected output phases into a queue; a monitor pops on every transfer.
module tb_interpolator;

  localparam int WL = 29;

`ifdef INTERPOLATOR_HOLD_EN
  localparam bit HoldMode = 1'b1;
`else
  localparam bit HoldMode = 1'b0;
`endif

  typedef logic signed [WL-1:0] word_t;

  typedef struct packed {
    int    dut;
    word_t data;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;

  word_t drv_in        = '0;
  logic  drv_in_valid  = 1'b0;
  logic  drv_out_ready = 1'b1;
  int    drv_sel       = 0;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];

  int    facs[4] = '{4, 3, 1, 8};

  word_t mon_out[4];
  logic  mon_out_valid[4];
  logic  mon_in_ready[4];

  int    gaps;
  int    ready_low;
  int    waited;
  logic  pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  interpolator_if #(.WordLengthBits(WL)) if_f4 ();
  interpolator_if #(.WordLengthBits(WL)) if_f3 ();
  interpolator_if #(.WordLengthBits(WL)) if_f1 ();
  interpolator_if #(.WordLengthBits(WL)) if_f8 ();

  assign if_f4.in = drv_in;
  assign if_f3.in = drv_in;
  assign if_f1.in = drv_in;
  assign if_f8.in = drv_in;
  assign if_f4.in_valid = drv_in_valid && (drv_sel == 0);
  assign if_f3.in_valid = drv_in_valid && (drv_sel == 1);
  assign if_f1.in_valid = drv_in_valid && (drv_sel == 2);
  assign if_f8.in_valid = drv_in_valid && (drv_sel == 3);
  assign if_f4.out_ready = drv_out_ready;
  assign if_f3.out_ready = drv_out_ready;
  assign if_f1.out_ready = drv_out_ready;
  assign if_f8.out_ready = drv_out_ready;

  assign mon_out[0] = if_f4.out;
  assign mon_out[1] = if_f3.out;
  assign mon_out[2] = if_f1.out;
  assign mon_out[3] = if_f8.out;
  assign mon_out_valid[0] = if_f4.out_valid;
  assign mon_out_valid[1] = if_f3.out_valid;
  assign mon_out_valid[2] = if_f1.out_valid;
  assign mon_out_valid[3] = if_f8.out_valid;
  assign mon_in_ready[0] = if_f4.in_ready;
  assign mon_in_ready[1] = if_f3.in_ready;
  assign mon_in_ready[2] = if_f1.in_ready;
  assign mon_in_ready[3] = if_f8.in_ready;

  interpolator #(.WordLengthBits(WL), .InterpolationFactor(4)) dut_f4 (.clk(clk), .rst(rst), .bus(if_f4));
  interpolator #(.WordLengthBits(WL), .InterpolationFactor(3)) dut_f3 (.clk(clk), .rst(rst), .bus(if_f3));
  interpolator #(.WordLengthBits(WL), .InterpolationFactor(1)) dut_f1 (.clk(clk), .rst(rst), .bus(if_f1));
  interpolator #(.WordLengthBits(WL), .InterpolationFactor(8)) dut_f8 (.clk(clk), .rst(rst), .bus(if_f8));

  always #5 clk = ~clk;

  function automatic word_t expValue(input word_t w, input int p);
    if (HoldMode || p == 0) return w;
    return '0;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word to the selected instance until accepted; the expected
  // phases go into the scoreboard just before the accepting edge.
  task automatic applyStimulus(input int d, input word_t w);
    int budget;
    budget = 0;
    drv_sel      = d;
    drv_in       = w;
    drv_in_valid = 1'b1;
    @(negedge clk);
    while (!mon_in_ready[d] && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!mon_in_ready[d]) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout dut%0d: in_ready stayed 0, expected 1", d);
    end else begin
      for (int p = 0; p < facs[d]; p++) exp_q.push_back('{dut: d, data: expValue(w, p)});
    end
    @(posedge clk);
    #1;
    drv_in_valid = 1'b0;
  endtask

  task automatic monitorLoop();
    bit    held[4]     = '{default: 1'b0};
    word_t held_val[4] = '{default: '0};
    exp_t  e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) held[i] = 1'b0;
        continue;
      end
      for (int i = 0; i < 4; i++) begin
        if (held[i]) begin
          checks++;
          if (!mon_out_valid[i] || mon_out[i] !== held_val[i]) begin
            errors++;
            $display("[TB] FAIL stall_stable dut%0d: got valid=%0b out=%0d, expected valid=1 out=%0d",
                     i, mon_out_valid[i], mon_out[i], held_val[i]);
          end
        end
        held[i]     = mon_out_valid[i] && !drv_out_ready;
        held_val[i] = mon_out[i];
        if (mon_out_valid[i] && drv_out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_out dut%0d: got %0d, expected no transfer", i, mon_out[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.dut != i || mon_out[i] !== e.data) begin
              errors++;
              $display("[TB] FAIL out_value: got dut%0d=%0d, expected dut%0d=%0d",
                       i, mon_out[i], e.dut, e.data);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    fork
      monitorLoop();
    join_none

    // Reset state.
    #12;
    checkOutput("rst_out_valid", mon_out_valid[0], 0);
    checkOutput("rst_out", mon_out[0], 0);
    checkOutput("rst_in_ready", mon_in_ready[0], 0);
    checkOutput("rst_in_ready_f1", mon_in_ready[2], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", mon_in_ready[0], 1);
    idle(1);

    // Single word, factor 4: 1-cycle latency then 123,0,0,0.
    applyStimulus(0, 123);
    @(negedge clk);
    checkOutput("latency_valid", mon_out_valid[0], 1);
    checkOutput("latency_value", mon_out[0], 123);
    idle(8);
    checkOutput("single_drained", exp_q.size(), 0);
    checkOutput("single_idle_valid", mon_out_valid[0], 0);

    // Back-to-back 5,-7,9 on factor 4: no output gaps, pending fills.
    gaps = 0;
    ready_low = 0;
    waited = 0;
    fork
      begin
        applyStimulus(0, 5);
        applyStimulus(0, -7);
        applyStimulus(0, 9);
      end
      begin
        @(negedge clk);
        while (!mon_out_valid[0] && waited < 20) begin
          @(negedge clk);
          waited++;
        end
        for (int k = 0; k < 12; k++) begin
          if (!mon_out_valid[0]) gaps++;
          if (!mon_in_ready[0]) ready_low++;
          @(negedge clk);
        end
      end
    join
    checkOutput("b2b_gaps", gaps, 0);
    checkOutput("b2b_in_ready_low_seen", (ready_low > 0) ? 1 : 0, 1);
    idle(6);
    checkOutput("b2b_drained", exp_q.size(), 0);
    checkOutput("b2b_idle_valid", mon_out_valid[0], 0);

    // Backpressure on factor 3 with out_ready pattern 1,0,0,1,0,1.
    applyStimulus(1, -1);
    for (int k = 0; k < 6; k++) begin
      drv_out_ready = pat[k];
      @(posedge clk);
      #1;
    end
    drv_out_ready = 1'b1;
    idle(3);
    checkOutput("bp_drained", exp_q.size(), 0);
    checkOutput("bp_idle_valid", mon_out_valid[1], 0);

    // Factor 1: continuous 10,20,30 with in_ready constantly high.
    ready_low = 0;
    fork
      begin
        applyStimulus(2, 10);
        applyStimulus(2, 20);
        applyStimulus(2, 30);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (!mon_in_ready[2]) ready_low++;
        end
      end
    join
    checkOutput("f1_in_ready_low_count", ready_low, 0);
    idle(3);
    checkOutput("f1_drained", exp_q.size(), 0);

    // Factor 1 stalled: two words held, then in_ready drops.
    drv_out_ready = 1'b0;
    applyStimulus(2, 1);
    applyStimulus(2, 2);
    @(negedge clk);
    checkOutput("f1_full_in_ready", mon_in_ready[2], 0);
    checkOutput("f1_full_out", mon_out[2], 1);
    @(posedge clk);
    #1;
    drv_out_ready = 1'b1;
    idle(4);
    checkOutput("f1_stall_drained", exp_q.size(), 0);
    checkOutput("f1_stall_in_ready", mon_in_ready[2], 1);

    // Factor 4, word 77 (hold build repeats it on every phase).
    applyStimulus(0, 77);
    idle(6);
    checkOutput("w77_drained", exp_q.size(), 0);

    // Async reset mid-burst on factor 8 at phase 3.
    applyStimulus(3, 99);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("midrst_out_valid", mon_out_valid[3], 0);
    checkOutput("midrst_out", mon_out[3], 0);
    checkOutput("midrst_in_ready", mon_in_ready[3], 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    checkOutput("midrst_no_leftover", mon_out_valid[3], 0);
    applyStimulus(3, 42);
    idle(12);
    checkOutput("midrst_drained", exp_q.size(), 0);
    checkOutput("midrst_idle_valid", mon_out_valid[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
